// File: rtl/fir_pkg.sv
// Shared FIR constants plus the round/saturate helper used by the decimating output stage.
package fir_pkg;

    localparam int unsigned IN_W   = 18;
    localparam int unsigned COEF_W = 16;

    typedef struct packed {
        logic [IN_W:0] value;
        logic          clip;
    } sat_res_t;

    // Round half toward +inf, arithmetic shift, then clamp to a signed out_w range.
    function automatic sat_res_t sat_round(input logic signed [IN_W:0] value,
                                           input int unsigned shift,
                                           input int unsigned out_w);
        logic signed [IN_W:0] half;
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] r;
        logic signed [IN_W:0] hi;
        logic signed [IN_W:0] lo;
        sat_res_t             res;
        half = (IN_W + 1)'(1) << (shift - 1);
        sum  = value + half;
        r    = sum >>> shift;
        hi   = ((IN_W + 1)'(1) << (out_w - 1)) - (IN_W + 1)'(1);
        lo   = ~hi;
        res.clip  = 1'b0;
        res.value = r;
        if (r > hi) begin
            res.value = hi;
            res.clip  = 1'b1;
        end else if (r < lo) begin
            res.value = lo;
            res.clip  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// Input sample and output stream signals of the decimating output stage.
interface fir_decim_out_if #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 12
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  din;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sat;
    logic                    overflow;

    modport master (
        output in_valid, din, out_ready,
        input  out_data, out_valid, sat, overflow
    );

    modport slave (
        input  in_valid, din, out_ready,
        output out_data, out_valid, sat, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word and flags are registered, head holds when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_nxt;

    // A push into a full FIFO only lands when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        rptr_nxt  = do_pop ? rptr + AW'(1) : rptr;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
        head_nxt = rdata;
        if (count_nxt != '0) begin
            head_nxt = (do_push && (wptr == rptr_nxt)) ? wdata : mem[rptr_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            rdata <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            rptr  <= rptr_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            rdata <= head_nxt;
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// Decimates the FIR output stream, rounds/saturates kept samples and buffers them for a valid/ready consumer.
module fir_decim_out #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned IN_W  = fir_pkg::IN_W,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    fir_decim_out_if.slave bus
);
    import fir_pkg::*;

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]    phase;
    logic             keep_c;
    sat_res_t         rs_c;
    logic             s1_valid;
    logic [OUT_W-1:0] s1_data;
    logic             pop;
    logic             full;
    logic             empty;
    logic [OUT_W-1:0] rdata;

    always_comb begin
        keep_c = bus.in_valid && (phase == '0);
        rs_c   = sat_round((fir_pkg::IN_W + 1)'(bus.din), SHIFT, OUT_W);
        pop    = !empty && bus.out_ready;
    end

    // sat is loaded with the stage-1 valid bit so it lines up with the push attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= '0;
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            bus.sat      <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
            end
            s1_valid <= keep_c;
            if (keep_c) begin
                s1_data <= OUT_W'(rs_c.value);
            end
            bus.sat <= keep_c && rs_c.clip;
            if (s1_valid && full && !pop) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s1_valid),
        .pop   (pop),
        .wdata (s1_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_data  = rdata;
    assign bus.out_valid = !empty;

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: one DECIM=4 instance and one DECIM=1 instance for rounding/saturation.
module tb_fir_decim_out;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic exp_v;

    int rnd_din [9] = '{100, -100, 96, 95, -32, -33, 131071, -131072, 131040};
    int rnd_exp [9] = '{2, -2, 2, 1, 0, -1, 2047, -2048, 2047};
    int rnd_sat [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};

    fir_decim_out_if #(.IN_W(18), .OUT_W(12)) ifc4 ();
    fir_decim_out_if #(.IN_W(18), .OUT_W(12)) ifc1 ();

    fir_decim_out #(.DECIM(4), .IN_W(18), .OUT_W(12), .SHIFT(6), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc4)
    );

    fir_decim_out #(.DECIM(1), .IN_W(18), .OUT_W(12), .SHIFT(6), .DEPTH(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        ifc4.in_valid = 1'b0;
        ifc1.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n          = 1'b0;
        ifc4.in_valid  = 1'b0;
        ifc4.din       = '0;
        ifc4.out_ready = 1'b0;
        ifc1.in_valid  = 1'b0;
        ifc1.din       = '0;
        ifc1.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(ifc4.out_valid), 0);
        chk("rst_data", 32'(ifc4.out_data), 0);
        chk("rst_sat", 32'(ifc4.sat), 0);
        chk("rst_ovf", 32'(ifc4.overflow), 0);
        chk("rst_valid1", 32'(ifc1.out_valid), 0);
        rst_n = 1'b1;
        step();

        // Ramp: every 4th sample kept, two-cycle latency, drained immediately.
        ifc4.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ifc4.in_valid = (i < 16);
            ifc4.din      = 18'(64 * i);
            step();
            exp_v = (i >= 1) && (i <= 16) && (((i - 1) % 4) == 0);
            chk("ramp_valid", 32'(ifc4.out_valid), 32'(exp_v));
            if (exp_v) chk("ramp_data", 32'(ifc4.out_data), i - 1);
        end
        ifc4.in_valid = 1'b0;

        // Rounding and saturation with DECIM=1, continuous stream.
        for (int k = 0; k < 10; k++) begin
            if (k < 9) begin
                ifc1.in_valid = 1'b1;
                ifc1.din      = 18'(rnd_din[k]);
            end else begin
                ifc1.in_valid = 1'b0;
            end
            step();
            if (k < 9) chk("rnd_sat", 32'(ifc1.sat), rnd_sat[k]);
            else       chk("rnd_sat_end", 32'(ifc1.sat), 0);
            if (k >= 1) begin
                chk("rnd_valid", 32'(ifc1.out_valid), 1);
                chk("rnd_data", 32'(ifc1.out_data), rnd_exp[k - 1]);
            end
        end

        // Backpressure: four buffered, fifth kept sample overflows.
        do_reset();
        ifc4.out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ifc4.in_valid = 1'b1;
            ifc4.din      = 18'(64 * i);
            step();
            chk("bp_ovf", 32'(ifc4.overflow), 32'(i >= 17));
        end
        ifc4.in_valid = 1'b0;
        step();
        chk("bp_hold_valid", 32'(ifc4.out_valid), 1);
        chk("bp_hold_data", 32'(ifc4.out_data), 0);
        ifc4.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_drain_valid", 32'(ifc4.out_valid), 1);
            chk("bp_drain_data", 32'(ifc4.out_data), 4 * j);
            step();
        end
        chk("bp_empty", 32'(ifc4.out_valid), 0);
        chk("bp_ovf_sticky", 32'(ifc4.overflow), 1);
        chk("bp_data_hold", 32'(ifc4.out_data), 12);

        // Full FIFO with a pop in the same cycle as the push.
        do_reset();
        ifc4.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ifc4.in_valid = 1'b1;
            ifc4.din      = 18'(64 * i);
            step();
        end
        chk("fp_pre_ovf", 32'(ifc4.overflow), 0);
        chk("fp_pre_data", 32'(ifc4.out_data), 0);
        ifc4.in_valid  = 1'b0;
        ifc4.out_ready = 1'b1;
        step();
        chk("fp_ovf", 32'(ifc4.overflow), 0);
        for (int j = 0; j < 4; j++) begin
            chk("fp_valid", 32'(ifc4.out_valid), 1);
            chk("fp_data", 32'(ifc4.out_data), 4 + 4 * j);
            step();
        end
        chk("fp_count", 32'(ifc4.out_valid), 0);
        chk("fp_ovf_end", 32'(ifc4.overflow), 0);

        // Gapped input: phase advances only on valid cycles.
        do_reset();
        ifc4.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if ((k % 2) == 0) begin
                ifc4.in_valid = 1'b1;
                ifc4.din      = 18'(64 * (k / 2 + 1));
            end else begin
                ifc4.in_valid = 1'b0;
                ifc4.din      = 18'(64 * 100);
            end
            step();
            exp_v = (k >= 1) && (((k - 1) % 8) == 0);
            chk("gap_valid", 32'(ifc4.out_valid), 32'(exp_v));
            if (exp_v) chk("gap_data", 32'(ifc4.out_data), (k - 1) / 2 + 1);
        end

        // Reset mid-burst with a sample in flight.
        ifc4.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ifc4.in_valid = 1'b1;
            ifc4.din      = 18'(64 * (20 + i));
            step();
        end
        chk("mr_valid", 32'(ifc4.out_valid), 1);
        chk("mr_data", 32'(ifc4.out_data), 22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(ifc4.out_valid), 0);
        chk("mr_async_data", 32'(ifc4.out_data), 0);
        ifc4.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mr_inflight_gone", 32'(ifc4.out_valid), 0);
        ifc4.in_valid = 1'b1;
        ifc4.din      = 18'(64 * 7);
        step();
        ifc4.din = 18'(64 * 8);
        step();
        ifc4.in_valid = 1'b0;
        chk("mr_first_valid", 32'(ifc4.out_valid), 1);
        chk("mr_first_data", 32'(ifc4.out_data), 7);
        ifc4.out_ready = 1'b1;
        step();
        step();
        chk("mr_second_dropped", 32'(ifc4.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
